// File: rtl/stream_arb_2to1.sv
// Packet-aware 2:1 round-robin stream arbiter with a registered output beat.
// Define STREAM_ARB_FIXED_PRIO_EN to make ch0 always win unlocked contention.
module stream_arb_2to1 #(
  parameter int data_width = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [data_width-1:0] i_data0,
  input  logic                  i_valid0,
  input  logic                  i_last0,
  output logic                  o_ready0,
  input  logic [data_width-1:0] i_data1,
  input  logic                  i_valid1,
  input  logic                  i_last1,
  output logic                  o_ready1,
  output logic [data_width-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_sel,
  input  logic                  i_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t           lock_q, lock_d;
  logic                  lock_ch_q, lock_ch_d;
  logic                  prio_q, prio_d;
  logic                  o_valid_q, o_valid_d;
  logic [data_width-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic                  o_sel_q, o_sel_d;

  logic                  load;
  logic                  gnt_valid;
  logic                  gnt_ch;
  logic                  xfer;
  logic [data_width-1:0] xfer_data;
  logic                  xfer_last;

  // Grant selection: a held lock overrides contention and the pointer.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = 1'b0;
    if (lock_q == LOCKED) begin
      gnt_valid = 1'b1;
      gnt_ch    = lock_ch_q;
    end else if (i_valid0 && i_valid1) begin
      gnt_valid = 1'b1;
      gnt_ch    = prio_q;
    end else if (i_valid0) begin
      gnt_valid = 1'b1;
      gnt_ch    = 1'b0;
    end else if (i_valid1) begin
      gnt_valid = 1'b1;
      gnt_ch    = 1'b1;
    end
  end

  assign load     = ~o_valid_q | i_ready;
  assign o_ready0 = ~i_rst & load & gnt_valid & ~gnt_ch;
  assign o_ready1 = ~i_rst & load & gnt_valid & gnt_ch;

  assign xfer      = (i_valid0 & o_ready0) | (i_valid1 & o_ready1);
  assign xfer_data = gnt_ch ? i_data1 : i_data0;
  assign xfer_last = gnt_ch ? i_last1 : i_last0;

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_sel_d   = o_sel_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    prio_d    = prio_q;

    if (xfer) begin
      o_valid_d = 1'b1;
      o_data_d  = xfer_data;
      o_last_d  = xfer_last;
      o_sel_d   = gnt_ch;
    end else if (i_ready) begin
      o_valid_d = 1'b0;
    end

    if (xfer) begin
      if (lock_q == IDLE && !xfer_last) begin
        lock_d    = LOCKED;
        lock_ch_d = gnt_ch;
      end else if (lock_q == LOCKED && xfer_last) begin
        lock_d = IDLE;
      end
    end

`ifdef STREAM_ARB_FIXED_PRIO_EN
    prio_d = 1'b0;
`else
    if (xfer && xfer_last) begin
      prio_d = ~gnt_ch;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_sel_q   <= 1'b0;
      lock_q    <= IDLE;
      lock_ch_q <= 1'b0;
      prio_q    <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_sel_q   <= o_sel_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      prio_q    <= prio_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_sel   = o_sel_q;

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Directed self-checking bench for stream_arb_2to1 (honours STREAM_ARB_FIXED_PRIO_EN).
module tb_stream_arb_2to1;

  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_data0, i_data1;
  logic          i_valid0, i_valid1, i_last0, i_last1;
  logic          o_ready0, o_ready1;
  logic [DW-1:0] o_data;
  logic          o_valid, o_last, o_sel;
  logic          i_ready;

  int checkCount = 0;
  int errorCount = 0;

  stream_arb_2to1 #(.data_width(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_data0(i_data0), .i_valid0(i_valid0), .i_last0(i_last0), .o_ready0(o_ready0),
    .i_data1(i_data1), .i_valid1(i_valid1), .i_last1(i_last1), .o_ready1(o_ready1),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_sel(o_sel),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [DW-1:0] d0, input logic l0,
                               input logic v1, input logic [DW-1:0] d1, input logic l1,
                               input logic rdy);
    i_valid0 = v0; i_data0 = d0; i_last0 = l0;
    i_valid1 = v1; i_data1 = d1; i_last1 = l1;
    i_ready  = rdy;
    #1;
  endtask

  // Advance one edge, then settle so registered outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [DW-1:0] d, input logic s, input logic l);
    checkOutput({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    checkOutput({tag, "_data"}, {24'b0, o_data}, {24'b0, d});
    checkOutput({tag, "_sel"}, {31'b0, o_sel}, {31'b0, s});
    checkOutput({tag, "_last"}, {31'b0, o_last}, {31'b0, l});
  endtask

  logic [DW-1:0] expData[4];
  logic          expSel[4];
  logic [DW-1:0] d0, d1;
  logic          r0, r1;

  initial begin
    // Reset with both channels valid
    i_rst = 1'b1;
    applyStimulus(1'b1, 8'hA0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1);
    tick();
    checkOutput("rst_ready0", {31'b0, o_ready0}, 32'd0);
    checkOutput("rst_ready1", {31'b0, o_ready1}, 32'd0);
    tick();
    checkOutput("rst_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_data", {24'b0, o_data}, 32'h00);
    checkOutput("rst_sel", {31'b0, o_sel}, 32'd0);
    checkOutput("rst_last", {31'b0, o_last}, 32'd0);
    i_rst = 1'b0;
    #1;
    checkOutput("first_ready0", {31'b0, o_ready0}, 32'd1);
    checkOutput("first_ready1", {31'b0, o_ready1}, 32'd0);

    // Contention with single-beat packets
`ifdef STREAM_ARB_FIXED_PRIO_EN
    expData = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    expSel  = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    expData = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    expSel  = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    d0 = 8'hA0;
    d1 = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      r0 = o_ready0;
      r1 = o_ready1;
      tick();
      checkBeat($sformatf("rr%0d", i), expData[i], expSel[i], 1'b1);
      if (r0) d0 = d0 + 8'd1;
      if (r1) d1 = d1 + 8'd1;
      applyStimulus(1'b1, d0, 1'b1, 1'b1, d1, 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("rr_drain_valid", {31'b0, o_valid}, 32'd0);

    // Packet lock: ch0 3-beat packet against constant ch1
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
    checkOutput("lock_ready0", {31'b0, o_ready0}, 32'd1);
    checkOutput("lock_ready1_a", {31'b0, o_ready1}, 32'd0);
    tick();
    checkBeat("lock_b1", 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
    checkOutput("lock_ready1_b", {31'b0, o_ready1}, 32'd0);
    tick();
    checkBeat("lock_b2", 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h13, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    checkOutput("lock_ready1_c", {31'b0, o_ready1}, 32'd0);
    tick();
    checkBeat("lock_b3", 8'h13, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
    checkOutput("lock_ready1_d", {31'b0, o_ready1}, 32'd1);
    tick();
    checkBeat("lock_ch1", 8'h55, 1'b1, 1'b1);

    // Backpressure while holding 0x12 mid-packet
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkBeat("bp_pre", 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h13, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp%0d_ready0", i), {31'b0, o_ready0}, 32'd0);
      checkOutput($sformatf("bp%0d_ready1", i), {31'b0, o_ready1}, 32'd0);
      tick();
      checkBeat($sformatf("bp%0d", i), 8'h12, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h13, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1);
    checkOutput("bp_rel_ready0", {31'b0, o_ready0}, 32'd1);
    tick();
    checkBeat("bp_next", 8'h13, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
    tick();
    checkBeat("bp_ch1", 8'h66, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("bp_drain_valid", {31'b0, o_valid}, 32'd0);

    // Bubble inside a locked ch1 packet
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
    tick();
    checkBeat("bub_b1", 8'h21, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("bub%0d_ready0", i), {31'b0, o_ready0}, 32'd0);
      tick();
      checkOutput($sformatf("bub%0d_valid", i), {31'b0, o_valid}, 32'd0);
    end
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    checkOutput("bub_ready0_c", {31'b0, o_ready0}, 32'd0);
    tick();
    checkBeat("bub_b2", 8'h22, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("bub_ready0_d", {31'b0, o_ready0}, 32'd1);
    tick();
    checkBeat("bub_ch0", 8'h77, 1'b0, 1'b1);

    // Reset in the middle of a locked ch1 packet
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h32, 1'b0, 1'b1);
    tick();
    checkBeat("mrst_b2", 8'h32, 1'b1, 1'b0);
    i_rst = 1'b1;
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    checkOutput("mrst_ready0", {31'b0, o_ready0}, 32'd0);
    checkOutput("mrst_ready1", {31'b0, o_ready1}, 32'd0);
    tick();
    checkOutput("mrst_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("mrst_data", {24'b0, o_data}, 32'h00);
    checkOutput("mrst_sel", {31'b0, o_sel}, 32'd0);
    checkOutput("mrst_last", {31'b0, o_last}, 32'd0);
    i_rst = 1'b0;
    #1;
    checkOutput("mrst_gnt0", {31'b0, o_ready0}, 32'd1);
    checkOutput("mrst_gnt1", {31'b0, o_ready1}, 32'd0);
    tick();
    checkBeat("mrst_after", 8'h44, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
